dac_ad5318_spi_master: RTL and testbench

Upstream command serializer for the dac_ad5318 serial port. It accepts parallel DAC commands (channel data writes or control words) over a valid/ready handshake and assembles each into a 16-bit frame. It shifts the frame out on SCLK/SYNC_b/DIN and optionally pulses LDAC_b. It sits between the system controller (CLK domain) and the DAC pins.

---
 rtl/dac_ad5318_pkg.sv | 36 +++
 rtl/dac_ad5318_spi_master_if.sv | 26 ++
 rtl/dac_sclk_gen.sv | 39 +++
 rtl/dac_ad5318_spi_master.sv | 134 +++++++++++++
 tb/tb_dac_ad5318_spi_master.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dac_ad5318_pkg.sv
// Shared types for the dac_ad5318 command serializer: control modes, master states and
// the 16-bit frame builder used when a command is captured.
package dac_ad5318_pkg;

   localparam int FRAME_BITS = 16;

   typedef enum logic [1:0] {
      CTRL_FUNCS = 2'b00,
      LDAC_CTRL  = 2'b01,
      POWER_DOWN = 2'b10,
      RESET      = 2'b11
   } ctrl_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT,
      ST_GAP,
      ST_LDAC
   } master_state_e;

   // Data write: {0, addr, data, 00}; control word: {1, mode, 00000, payload}.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic             kind,
      input logic [2:0]       addr,
      input logic [9:0]       data,
      input ctrl_mode_e       mode,
      input logic [7:0]       payload
   );
      if (kind) begin
         return {1'b1, mode, 5'b00000, payload};
      end
      return {1'b0, addr, data, 2'b00};
   endfunction

endpackage

// File: rtl/dac_ad5318_spi_master_if.sv
// Command handshake between the system controller and the serializer; cmd_ready is only
// high while the serializer is idle, busy/done report progress of the captured command.
interface dac_ad5318_spi_master_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_kind;
   logic [2:0] cmd_addr;
   logic [9:0] cmd_data;
   logic [1:0] cmd_mode;
   logic [7:0] cmd_payload;
   logic       cmd_ldac;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid, cmd_kind, cmd_addr, cmd_data, cmd_mode, cmd_payload, cmd_ldac,
      input  cmd_ready, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_addr, cmd_data, cmd_mode, cmd_payload, cmd_ldac,
      output cmd_ready, busy, done
   );

endinterface

// File: rtl/dac_sclk_gen.sv
// SCLK half-period generator: registered level toggling every CLK_DIV enabled cycles;
// rise/fall are one-cycle ticks flagging the cycle before SCLK goes high/low.
module dac_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = en && !clr && (cnt == LAST);
   assign rise = wrap && !sclk;
   assign fall = wrap && sclk;

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt  <= '0;
            sclk <= !sclk;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dac_ad5318_spi_master.sv
// Serializes one DAC command per handshake into a 16-bit SYNC_b-framed word, adds one commit
// SCLK edge, a SYNC_b gap and an optional LDAC_b pulse; no new command is taken until done.
module dac_ad5318_spi_master
   import dac_ad5318_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int SYNC_GAP  = 4,
   parameter int LDAC_LEN  = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic                          CLK,
   input  logic                          RST,
   dac_ad5318_spi_master_if.slave        bus,
   output logic                          SCLK,
   output logic                          SYNC_b,
   output logic                          DIN,
   output logic                          LDAC_b
);

   localparam int            TMAX      = (SYNC_GAP > LDAC_LEN) ? SYNC_GAP : LDAC_LEN;
   localparam int            TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] GAP_LAST  = TW'(SYNC_GAP - 1);
   localparam logic [TW-1:0] LDAC_LAST = TW'(LDAC_LEN - 1);
   localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);
   localparam bit            MSB       = (MSB_FIRST != 0);

   master_state_e         state, state_nxt;
   logic [FRAME_BITS-1:0] frame_in;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] shreg_shifted;
   logic [3:0]            bit_cnt;
   logic [TW-1:0]         tcnt;
   logic                  ldac_pend;
   logic                  accept;
   logic                  sclk_en;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  last_bit;
   logic                  din_first;
   logic                  din_next;
   logic                  sync_b_nxt;
   logic                  ldac_b_nxt;
   logic                  done_nxt;

   assign bus.cmd_ready = (state == ST_IDLE) && !RST;
   assign bus.busy      = (state != ST_IDLE);
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign sclk_en       = (state == ST_SHIFT) || (state == ST_COMMIT);
   assign last_bit      = (bit_cnt == BIT_LAST);

   assign frame_in = build_frame(bus.cmd_kind, bus.cmd_addr, bus.cmd_data,
                                 ctrl_mode_e'(bus.cmd_mode), bus.cmd_payload);

   assign shreg_shifted = MSB ? {shreg[FRAME_BITS-2:0], 1'b0} : {1'b0, shreg[FRAME_BITS-1:1]};
   assign din_first     = MSB ? frame_in[FRAME_BITS-1] : frame_in[0];
   assign din_next      = MSB ? shreg_shifted[FRAME_BITS-1] : shreg_shifted[0];

   // SCLK keeps running from SHIFT straight into COMMIT so the commit edge has the same period.
   dac_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .CLK  (CLK),
      .RST  (RST),
      .en   (sclk_en),
      .clr  (!sclk_en),
      .sclk (SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sync_b_nxt = 1'b1;
      ldac_b_nxt = 1'b1;
      done_nxt   = 1'b0;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT:  if (sclk_fall && last_bit) state_nxt = ST_COMMIT;
         ST_COMMIT: if (sclk_fall) state_nxt = ST_GAP;
         ST_GAP:    if (tcnt == GAP_LAST) state_nxt = ldac_pend ? ST_LDAC : ST_IDLE;
         ST_LDAC:   if (tcnt == LDAC_LAST) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      sync_b_nxt = (state_nxt != ST_SHIFT);
      ldac_b_nxt = (state_nxt != ST_LDAC);
      done_nxt   = (state != ST_IDLE) && (state_nxt == ST_IDLE);
   end

   // DIN only moves on the falling-edge tick, so it is stable across every SCLK rise.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         tcnt      <= '0;
         ldac_pend <= 1'b0;
         DIN       <= 1'b0;
         SYNC_b    <= 1'b1;
         LDAC_b    <= 1'b1;
         bus.done  <= 1'b0;
      end else begin
         SYNC_b   <= sync_b_nxt;
         LDAC_b   <= ldac_b_nxt;
         bus.done <= done_nxt;
         tcnt     <= ((state == ST_GAP || state == ST_LDAC) && state_nxt == state)
                     ? tcnt + TW'(1) : '0;
         if (accept) begin
            shreg     <= frame_in;
            bit_cnt   <= '0;
            ldac_pend <= bus.cmd_ldac;
            DIN       <= din_first;
         end else if (state == ST_SHIFT && sclk_fall) begin
            if (last_bit) begin
               DIN <= 1'b0;
            end else begin
               shreg   <= shreg_shifted;
               bit_cnt <= bit_cnt + 4'd1;
               DIN     <= din_next;
            end
         end
      end
   end

   a_edge_framing: assert property (@(posedge CLK) disable iff (RST)
      sclk_rise |-> (SYNC_b == (state == ST_COMMIT)));

endmodule

// File: tb/tb_dac_ad5318_spi_master.sv
// Drives identical command streams into an LSB-first and an MSB-first serializer; per-DUT
// monitors deserialize the pins and score each finished command against queued expectations.
module tb_dac_ad5318_spi_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       c_valid = 1'b0;
   logic       c_kind = 1'b0;
   logic [2:0] c_addr = '0;
   logic [9:0] c_data = '0;
   logic [1:0] c_mode = '0;
   logic [7:0] c_payload = '0;
   logic       c_ldac = 1'b0;

   dac_ad5318_spi_master_if bus0 ();
   dac_ad5318_spi_master_if bus1 ();

   assign bus0.cmd_valid = c_valid;   assign bus1.cmd_valid = c_valid;
   assign bus0.cmd_kind = c_kind;     assign bus1.cmd_kind = c_kind;
   assign bus0.cmd_addr = c_addr;     assign bus1.cmd_addr = c_addr;
   assign bus0.cmd_data = c_data;     assign bus1.cmd_data = c_data;
   assign bus0.cmd_mode = c_mode;     assign bus1.cmd_mode = c_mode;
   assign bus0.cmd_payload = c_payload; assign bus1.cmd_payload = c_payload;
   assign bus0.cmd_ldac = c_ldac;     assign bus1.cmd_ldac = c_ldac;

   logic [1:0] sclk, sync_b, din, ldac_b;
   logic [1:0] bsy, dne;
   assign bsy = {bus1.busy, bus0.busy};
   assign dne = {bus1.done, bus0.done};

   dac_ad5318_spi_master #(.CLK_DIV(2), .SYNC_GAP(4), .LDAC_LEN(2), .MSB_FIRST(0)) dut0 (
      .CLK(clk), .RST(rst), .bus(bus0),
      .SCLK(sclk[0]), .SYNC_b(sync_b[0]), .DIN(din[0]), .LDAC_b(ldac_b[0]));

   dac_ad5318_spi_master #(.CLK_DIV(2), .SYNC_GAP(4), .LDAC_LEN(2), .MSB_FIRST(1)) dut1 (
      .CLK(clk), .RST(rst), .bus(bus1),
      .SCLK(sclk[1]), .SYNC_b(sync_b[1]), .DIN(din[1]), .LDAC_b(ldac_b[1]));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [15:0] frame;
      int          hs;
      int          lat;
      int          nldac;
      int          shigh;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   logic [15:0] msh   [2] = '{16'h0, 16'h0};
   int          nb    [2] = '{0, 0};
   int          ncom  [2] = '{0, 0};
   int          nlow  [2] = '{0, 0};
   int          nhi   [2] = '{0, 0};
   int          ndin  [2] = '{0, 0};
   logic        psclk [2] = '{1'b0, 1'b0};
   logic        pdin  [2] = '{1'b0, 1'b0};

   task automatic mon(input int id, input logic s, input logic sy, input logic d,
                      input logic lb, input logic bz, input logic dn);
      exp_t e;
      bit   have;
      have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (bz) begin
         if (s && !psclk[id]) begin
            if (!sy) begin
               msh[id] = (id == 1) ? {msh[id][14:0], d} : {d, msh[id][15:1]};
               nb[id]++;
            end else begin
               ncom[id]++;
            end
         end
         if (s && d != pdin[id]) ndin[id]++;
         if (!lb) nlow[id]++;
         if (sy) nhi[id]++;
      end
      if (dn) begin
         if (!have) begin
            check($sformatf("d%0d done_without_command", id), 1, 0);
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("d%0d frame", id), int'(msh[id]), int'(e.frame));
            check($sformatf("d%0d data_edges", id), nb[id], 16);
            check($sformatf("d%0d commit_edges", id), ncom[id], 1);
            check($sformatf("d%0d latency", id), cyc - e.hs, e.lat);
            check($sformatf("d%0d sync_high_busy", id), nhi[id], e.shigh);
            check($sformatf("d%0d ldac_low", id), nlow[id], e.nldac);
            check($sformatf("d%0d din_moved_sclk_high", id), ndin[id], 0);
         end
      end
      if (!bz) begin
         msh[id] = '0; nb[id] = 0; ncom[id] = 0; nlow[id] = 0; nhi[id] = 0; ndin[id] = 0;
      end
      psclk[id] = s;
      pdin[id]  = d;
   endtask

   always @(negedge clk) mon(0, sclk[0], sync_b[0], din[0], ldac_b[0], bsy[0], dne[0]);
   always @(negedge clk) mon(1, sclk[1], sync_b[1], din[1], ldac_b[1], bsy[1], dne[1]);

   // Called at a negedge; returns at the negedge after the handshake cycle.
   task automatic send(input logic kind, input logic [2:0] addr, input logic [9:0] data,
                       input logic [1:0] mode, input logic [7:0] pl, input logic ldac,
                       input logic [15:0] ef, input bit expect_it, input bit keep,
                       output int hs);
      exp_t e;
      int   t;
      c_kind = kind; c_addr = addr; c_data = data; c_mode = mode;
      c_payload = pl; c_ldac = ldac; c_valid = 1'b1;
      t = 0;
      while (!bus0.cmd_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      hs = cyc;
      if (!bus0.cmd_ready) begin
         check("handshake_timeout", 0, 1);
      end else if (expect_it) begin
         e.frame = ef;
         e.hs    = cyc;
         e.lat   = ldac ? 75 : 73;
         e.nldac = ldac ? 2 : 0;
         e.shigh = ldac ? 10 : 8;
         q0.push_back(e);
         q1.push_back(e);
      end
      @(negedge clk);
      if (!keep) c_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   hs_a, hs_b, t, rises, nbad;
      logic ps;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d rst_sclk", i), int'(sclk[i]), 0);
         check($sformatf("d%0d rst_sync_b", i), int'(sync_b[i]), 1);
         check($sformatf("d%0d rst_din", i), int'(din[i]), 0);
         check($sformatf("d%0d rst_ldac_b", i), int'(ldac_b[i]), 1);
         check($sformatf("d%0d rst_busy", i), int'(bsy[i]), 0);
         check($sformatf("d%0d rst_done", i), int'(dne[i]), 0);
      end
      check("rst_ready", int'(bus0.cmd_ready), 1);

      send(1'b1, 3'd0, 10'h000, 2'b10, 8'h00, 1'b0, 16'hC000, 1, 0, hs_a);
      send(1'b1, 3'd0, 10'h000, 2'b01, 8'h00, 1'b0, 16'hA000, 1, 0, hs_a);
      send(1'b0, 3'd5, 10'h2AB, 2'b00, 8'h00, 1'b0, 16'h5AAC, 1, 0, hs_a);

      send(1'b0, 3'd0, 10'h3FF, 2'b00, 8'h00, 1'b0, 16'h0FFC, 1, 1, hs_a);
      send(1'b0, 3'd7, 10'h001, 2'b00, 8'h00, 1'b0, 16'h7004, 1, 0, hs_b);
      check("b2b_handshake_spacing", hs_b - hs_a, 73);

      send(1'b0, 3'd2, 10'h155, 2'b00, 8'h00, 1'b1, 16'h2554, 1, 0, hs_a);

      send(1'b0, 3'd1, 10'h0AA, 2'b00, 8'h00, 1'b0, 16'h0000, 0, 0, hs_a);
      rises = 0; ps = sclk[0]; t = 0;
      while (rises < 7 && t < 200) begin
         @(negedge clk);
         t++;
         if (sclk[0] && !ps) rises++;
         ps = sclk[0];
      end
      check("abort_rises_reached", rises, 7);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d abort_sclk", i), int'(sclk[i]), 0);
         check($sformatf("d%0d abort_sync_b", i), int'(sync_b[i]), 1);
         check($sformatf("d%0d abort_din", i), int'(din[i]), 0);
         check($sformatf("d%0d abort_busy", i), int'(bsy[i]), 0);
         check($sformatf("d%0d abort_done", i), int'(dne[i]), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", int'(bus0.cmd_ready), 1);

      send(1'b0, 3'd3, 10'h200, 2'b00, 8'h00, 1'b0, 16'h3800, 1, 0, hs_a);
      send(1'b1, 3'd0, 10'h000, 2'b00, 8'h3F, 1'b0, 16'h803F, 1, 0, hs_a);

      send(1'b0, 3'd6, 10'h123, 2'b00, 8'h00, 1'b0, 16'h648C, 1, 0, hs_a);
      t = 0; nbad = 0;
      while (t < 200) begin
         if (!bus0.busy) break;
         if (bus0.cmd_ready || bus1.cmd_ready) nbad++;
         c_addr  = ~c_addr;
         c_data  = ~c_data ^ 10'(t);
         c_valid = 1'b1;
         @(negedge clk);
         t++;
      end
      c_valid = 1'b0;
      check("toggle_ready_low", nbad, 0);
      check("toggle_completed", int'(t < 200), 1);

      t = 0;
      while ((q0.size() + q1.size()) != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", q0.size() + q1.size(), 0);
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
